banked_mem: RTL and testbench

BANKED_MEM -- requirements
Module: banked_mem

---
 rtl/banked_mem_pkg.sv | 26 ++
 rtl/banked_mem_sat_cnt.sv | 34 +++
 rtl/banked_mem.sv | 114 +++++++++++
 tb/tb_banked_mem.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/banked_mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : banked_mem_pkg
// Description : Shared defaults, response status type and bank-width helper
//               for the banked memory block.
// Revision    : 1.0 - initial release
// ============================================================================
package banked_mem_pkg;

  localparam int DEF_DATA_W    = 8;
  localparam int DEF_ADDR_W    = 4;
  localparam int DEF_NUM_BANKS = 4;
  localparam int DEF_CNT_W     = 32;

  typedef enum logic {
    OK       = 1'b0,
    ERR_BANK = 1'b1
  } rsp_status_e;

  // A single bank still needs a 1-bit select so out-of-range requests exist.
  function automatic int bank_w(input int num_banks);
    return (num_banks > 1) ? $clog2(num_banks) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/banked_mem_sat_cnt.sv
`default_nettype none
// ============================================================================
// Module      : banked_mem_sat_cnt
// Description : Saturating event counter with synchronous clear priority.
// Revision    : 1.0 - initial release
// ============================================================================
module banked_mem_sat_cnt
  import banked_mem_pkg::*;
#(
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_count <= '0;
    end else if (clr) begin
      r_count <= '0;
    end else if (inc && (r_count != {CNT_W{1'b1}})) begin
      r_count <= r_count + 1'b1;
    end
  end

  assign count = r_count;

endmodule
`default_nettype wire

// File: rtl/banked_mem.sv
`default_nettype none
// ============================================================================
// Module      : banked_mem
// Description : Multi-bank single-port memory with valid/ready request and
//               read-response channels plus saturating access statistics.
// Revision    : 1.0 - initial release
// ============================================================================
module banked_mem
  import banked_mem_pkg::*;
#(
  parameter int DATA_W    = DEF_DATA_W,
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int NUM_BANKS = DEF_NUM_BANKS,
  parameter int CNT_W     = DEF_CNT_W
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         req_valid,
  output logic                         req_ready,
  input  logic                         req_write,
  input  logic [bank_w(NUM_BANKS)-1:0] req_bank,
  input  logic [ADDR_W-1:0]            req_addr,
  input  logic [DATA_W-1:0]            req_wdata,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [DATA_W-1:0]            rsp_rdata,
  output logic                         rsp_err,
  input  logic                         clr_counters,
  output logic [CNT_W-1:0]             wr_count,
  output logic [CNT_W-1:0]             rd_count,
  output logic [CNT_W-1:0]             err_count
);

  localparam int              BANK_W      = bank_w(NUM_BANKS);
  localparam int              DEPTH       = 2 ** ADDR_W;
  localparam logic [BANK_W:0] C_NUM_BANKS = (BANK_W + 1)'(NUM_BANKS);

  logic [DATA_W-1:0] r_mem [NUM_BANKS][DEPTH];

  logic              r_rsp_valid;
  logic [DATA_W-1:0] r_rsp_rdata;
  rsp_status_e       r_rsp_status;

  logic              w_accept;
  logic              w_in_range;
  logic              w_wr_ok;
  logic              w_rd_acc;
  logic              w_rd_ok;
  logic              w_err;
  logic [DATA_W-1:0] w_rd_word;

  assign req_ready  = !r_rsp_valid || rsp_ready;
  assign w_accept   = req_valid && req_ready;
  assign w_in_range = ({1'b0, req_bank} < C_NUM_BANKS);
  assign w_wr_ok    = w_accept && req_write && w_in_range;
  assign w_rd_acc   = w_accept && !req_write;
  assign w_rd_ok    = w_rd_acc && w_in_range;
  assign w_err      = w_accept && !w_in_range;
  assign w_rd_word  = w_in_range ? r_mem[req_bank][req_addr] : '0;

  // Storage is deliberately left out of reset so contents survive rst_n.
  always_ff @(posedge clk) begin
    if (w_wr_ok) begin
      r_mem[req_bank][req_addr] <= req_wdata;
    end
  end

  // A new read replaces a consumed response at the same edge (no bubble).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_status <= OK;
    end else if (w_rd_acc) begin
      r_rsp_valid  <= 1'b1;
      r_rsp_rdata  <= w_rd_word;
      r_rsp_status <= w_in_range ? OK : ERR_BANK;
    end else if (rsp_ready) begin
      r_rsp_valid  <= 1'b0;
      r_rsp_rdata  <= '0;
      r_rsp_status <= OK;
    end
  end

  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = (r_rsp_status == ERR_BANK);

  banked_mem_sat_cnt #(.CNT_W(CNT_W)) u_wr_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_wr_ok),
    .clr   (clr_counters),
    .count (wr_count)
  );

  banked_mem_sat_cnt #(.CNT_W(CNT_W)) u_rd_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_rd_ok),
    .clr   (clr_counters),
    .count (rd_count)
  );

  banked_mem_sat_cnt #(.CNT_W(CNT_W)) u_err_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .inc   (w_err),
    .clr   (clr_counters),
    .count (err_count)
  );

endmodule
`default_nettype wire

// File: tb/tb_banked_mem.sv
`default_nettype none
// ============================================================================
// Module      : tb_banked_mem
// Description : Self-checking bench for banked_mem (3 banks, 4-bit counters).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_banked_mem;

  localparam int DW  = 8;
  localparam int AW  = 4;
  localparam int NB  = 3;
  localparam int CW  = 4;
  localparam int BW  = 2;
  localparam int CMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_write = 1'b0;
  logic [BW-1:0] req_bank = '0;
  logic [AW-1:0] req_addr = '0;
  logic [DW-1:0] req_wdata = '0;
  logic          rsp_valid;
  logic          rsp_ready = 1'b1;
  logic [DW-1:0] rsp_rdata;
  logic          rsp_err;
  logic          clr_counters = 1'b0;
  logic [CW-1:0] wr_count;
  logic [CW-1:0] rd_count;
  logic [CW-1:0] err_count;

  int total = 0;
  int bad   = 0;

  banked_mem #(.DATA_W(DW), .ADDR_W(AW), .NUM_BANKS(NB), .CNT_W(CW)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_bank     (req_bank),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_rdata    (rsp_rdata),
    .rsp_err      (rsp_err),
    .clr_counters (clr_counters),
    .wr_count     (wr_count),
    .rd_count     (rd_count),
    .err_count    (err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: request/response rules expressed with a sparse array.
  logic [DW-1:0] m_mem [int];
  bit            m_valid = 0;
  logic [DW-1:0] m_rdata = '0;
  bit            m_err   = 0;
  int            m_wr = 0, m_rd = 0, m_er = 0;

  function automatic int sat_inc(input int c);
    return (c >= CMAX) ? CMAX : c + 1;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid = 0; m_rdata = '0; m_err = 0;
      m_wr = 0; m_rd = 0; m_er = 0;
    end else begin
      bit acc, inr;
      int key;
      acc = req_valid && (!m_valid || rsp_ready);
      inr = (int'(req_bank) < NB);
      key = int'(req_bank) * 16 + int'(req_addr);
      if (acc && !req_write) begin
        m_valid = 1;
        m_rdata = inr ? m_mem[key] : '0;
        m_err   = !inr;
      end else if (rsp_ready) begin
        m_valid = 0; m_rdata = '0; m_err = 0;
      end
      if (acc && req_write && inr) m_mem[key] = req_wdata;
      if (clr_counters) begin
        m_wr = 0; m_rd = 0; m_er = 0;
      end else if (acc) begin
        if (!inr)           m_er = sat_inc(m_er);
        else if (req_write) m_wr = sat_inc(m_wr);
        else                m_rd = sat_inc(m_rd);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_req_ready", 32'(req_ready), 32'(!m_valid || rsp_ready));
      chk("cmp_rsp_valid", 32'(rsp_valid), 32'(m_valid));
      chk("cmp_rsp_rdata", 32'(rsp_rdata), 32'(m_rdata));
      chk("cmp_rsp_err",   32'(rsp_err),   32'(m_err));
      chk("cmp_wr_count",  32'(wr_count),  32'(m_wr));
      chk("cmp_rd_count",  32'(rd_count),  32'(m_rd));
      chk("cmp_err_count", 32'(err_count), 32'(m_er));
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic w, input logic [BW-1:0] b,
                     input logic [AW-1:0] a, input logic [DW-1:0] d, input logic rr);
    req_valid = v; req_write = w; req_bank = b; req_addr = a; req_wdata = d; rsp_ready = rr;
  endtask

  task automatic idle();
    req(1'b0, 1'b0, 2'd0, 4'd0, 8'h00, 1'b1);
  endtask

  initial begin
    // Reset
    idle();
    repeat (3) cycle();
    chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
    chk("rst_req_ready", 32'(req_ready), 32'd1);
    chk("rst_wr_count",  32'(wr_count),  32'd0);
    rst_n = 1'b1;
    cycle();

    // Write then read same location next cycle
    req(1'b1, 1'b1, 2'd2, 4'd7, 8'hA5, 1'b1);
    cycle();
    chk("wr_count_1", 32'(wr_count), 32'd1);
    req(1'b1, 1'b0, 2'd2, 4'd7, 8'h00, 1'b1);
    cycle();
    chk("rd1_valid", 32'(rsp_valid), 32'd1);
    chk("rd1_rdata", 32'(rsp_rdata), 32'hA5);
    chk("rd1_err",   32'(rsp_err),   32'd0);
    chk("rd1_rd_count", 32'(rd_count), 32'd1);
    idle();
    cycle();
    chk("rd1_drop_valid", 32'(rsp_valid), 32'd0);
    chk("rd1_drop_rdata", 32'(rsp_rdata), 32'd0);

    // Backpressure then back-to-back read
    req(1'b1, 1'b1, 2'd1, 4'd3, 8'h3C, 1'b1); cycle();
    req(1'b1, 1'b1, 2'd0, 4'd0, 8'h5A, 1'b1); cycle();
    req(1'b1, 1'b0, 2'd1, 4'd3, 8'h00, 1'b0); cycle();
    req(1'b1, 1'b0, 2'd0, 4'd0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk("bp_req_ready", 32'(req_ready), 32'd0);
      chk("bp_valid",     32'(rsp_valid), 32'd1);
      chk("bp_rdata",     32'(rsp_rdata), 32'h3C);
      cycle();
    end
    rsp_ready = 1'b1;
    #1;
    chk("bp_release_ready", 32'(req_ready), 32'd1);
    cycle();
    chk("b2b_valid", 32'(rsp_valid), 32'd1);
    chk("b2b_rdata", 32'(rsp_rdata), 32'h5A);
    chk("b2b_rd_count", 32'(rd_count), 32'd3);
    idle(); cycle();

    // Out-of-range bank
    req(1'b1, 1'b1, 2'd3, 4'd7, 8'hFF, 1'b1); cycle();
    req(1'b1, 1'b0, 2'd3, 4'd7, 8'h00, 1'b1); cycle();
    chk("oor_valid", 32'(rsp_valid), 32'd1);
    chk("oor_rdata", 32'(rsp_rdata), 32'd0);
    chk("oor_err",   32'(rsp_err),   32'd1);
    chk("oor_err_count", 32'(err_count), 32'd2);
    chk("oor_wr_count",  32'(wr_count),  32'd3);
    req(1'b1, 1'b0, 2'd2, 4'd7, 8'h00, 1'b1); cycle();
    chk("oor_mem_intact", 32'(rsp_rdata), 32'hA5);
    idle(); cycle();

    // Saturation and clear priority
    for (int i = 0; i < 20; i++) begin
      req(1'b1, 1'b1, 2'd0, 4'(i), 8'(i + 8'h10), 1'b1);
      cycle();
    end
    chk("sat_wr_count", 32'(wr_count), 32'd15);
    req(1'b1, 1'b1, 2'd0, 4'd1, 8'h77, 1'b1);
    clr_counters = 1'b1;
    cycle();
    clr_counters = 1'b0;
    chk("clr_wr_count",  32'(wr_count),  32'd0);
    chk("clr_rd_count",  32'(rd_count),  32'd0);
    chk("clr_err_count", 32'(err_count), 32'd0);

    // Asynchronous reset while a response is pending
    req(1'b1, 1'b0, 2'd0, 4'd1, 8'h00, 1'b0); cycle();
    chk("pre_rst_valid", 32'(rsp_valid), 32'd1);
    chk("pre_rst_rd_count", 32'(rd_count), 32'd1);
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid",    32'(rsp_valid), 32'd0);
    chk("arst_rdata",    32'(rsp_rdata), 32'd0);
    chk("arst_rd_count", 32'(rd_count),  32'd0);
    chk("arst_wr_count", 32'(wr_count),  32'd0);
    chk("arst_req_ready", 32'(req_ready), 32'd1);
    cycle();
    rst_n = 1'b1;
    cycle();
    req(1'b1, 1'b0, 2'd0, 4'd1, 8'h00, 1'b1); cycle();
    chk("post_rst_mem_0_1", 32'(rsp_rdata), 32'h77);
    req(1'b1, 1'b0, 2'd2, 4'd7, 8'h00, 1'b1); cycle();
    chk("post_rst_mem_2_7", 32'(rsp_rdata), 32'hA5);
    idle();
    repeat (2) cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
